// File: rtl/schmitt_debounce_bank.sv
// schmitt_debounce_bank
//   Bank of independent debounced digital inputs. Each channel resynchronizes
//   an asynchronous raw input, accepts a new level only after it has been seen
//   for STABLE_CYCLES consecutive enabled cycles, optionally inverts it, and
//   flags accepted transitions with one-cycle rise/fall pulses.
//
// Parameters
//   CHANNELS      number of independent channels (1..32)
//   INVERT_MASK   per-channel output inversion (bit=1 -> inverting)
//   STABLE_CYCLES consecutive synchronized cycles a new level must persist
//   SYNC_STAGES   synchronizer flip-flop depth (2..4)
//
// Ports
//   clk   in   1         rising-edge clock
//   rst   in   1         synchronous active-high reset (priority over en)
//   en    in   1         count/update enable; synchronizers always run
//   a     in   CHANNELS  asynchronous raw inputs
//   y     out  CHANNELS  debounced level, XOR INVERT_MASK
//   rise  out  CHANNELS  one-cycle pulse after y[i] goes 0->1
//   fall  out  CHANNELS  one-cycle pulse after y[i] goes 1->0
module schmitt_debounce_bank #(
  parameter int unsigned          CHANNELS      = 6,
  parameter logic [CHANNELS-1:0]  INVERT_MASK   = {CHANNELS{1'b1}},
  parameter int unsigned          STABLE_CYCLES = 4,
  parameter int unsigned          SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int unsigned CW_RAW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] f_q, f_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] y_d;

  // Synchronizer stage: free-running regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= a;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Acceptance stage: per-channel mismatch counter and accepted level
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en) begin
        if (s[i] == f_q[i]) begin
          // Any return to the accepted level discards the partial count.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          f_d[i]   = s[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // Edge flags are taken on the output polarity; f_d == f_q when en=0,
    // so the pulses drop to zero while frozen.
    y_d    = f_d ^ INVERT_MASK;
    rise_d = y_d & ~y;
    fall_d = ~y_d & y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      f_q    <= f_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output stage: y straight from the accepted-level register
  assign y    = f_q ^ INVERT_MASK;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_schmitt_debounce_bank.sv
// Directed bench for schmitt_debounce_bank with CHANNELS=6, STABLE_CYCLES=4,
// SYNC_STAGES=2. Instance dut uses an all-inverting mask, dut2 a mixed mask.
module tb_schmitt_debounce_bank;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [5:0] a, y, rise, fall;
  logic       rst2, en2;
  logic [5:0] a2, y2, rise2, fall2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  schmitt_debounce_bank #(
    .CHANNELS(6), .INVERT_MASK(6'b111111), .STABLE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y), .rise(rise), .fall(fall)
  );

  schmitt_debounce_bank #(
    .CHANNELS(6), .INVERT_MASK(6'b111110), .STABLE_CYCLES(4), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .a(a2), .y(y2), .rise(rise2), .fall(fall2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; a = 6'b101010;
    rst2 = 1'b1; en2 = 1'b1; a2 = 6'b000011;
    #1;

    // Reset and first acceptance
    step(1);
    chk("rst_y", y, 6'b111111);
    chk("rst_rise", rise, 6'b0);
    chk("rst_fall", fall, 6'b0);
    step(1);
    chk("rst_y2", y, 6'b111111);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk("acc_y_hold", y, 6'b111111);
      chk("acc_fall_hold", fall, 6'b0);
      chk("acc_rise_hold", rise, 6'b0);
    end
    step(1);
    chk("acc_y", y, 6'b010101);
    chk("acc_fall", fall, 6'b101010);
    chk("acc_rise", rise, 6'b0);
    step(1);
    chk("acc_fall_clr", fall, 6'b0);
    chk("acc_y_keep", y, 6'b010101);
    chk("acc_rise_clr", rise, 6'b0);
    step(3);

    // Glitch of 3 cycles on channel 0
    a[0] = 1'b1;
    step(3);
    a[0] = 1'b0;
    for (int e = 4; e <= 10; e++) begin
      step(1);
      chk("gl_y0", y[0], 1'b1);
      chk("gl_rise0", rise[0], 1'b0);
      chk("gl_fall0", fall[0], 1'b0);
    end

    // Minimum accept (4 cycles) then return
    a[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk("min_y0_pre", y[0], 1'b1);
      if (e == 4) a[0] = 1'b0;
    end
    step(1);
    chk("min_y0_fell", y[0], 1'b0);
    chk("min_fall0", fall[0], 1'b1);
    step(1);
    chk("min_fall0_clr", fall[0], 1'b0);
    chk("min_y0_low", y[0], 1'b0);
    step(2);
    chk("min_y0_low2", y[0], 1'b0);
    step(1);
    chk("min_y0_back", y[0], 1'b1);
    chk("min_rise0", rise[0], 1'b1);
    chk("min_fall0_q", fall[0], 1'b0);
    step(1);
    chk("min_rise0_clr", rise[0], 1'b0);
    step(3);

    // Enable freeze with count held at 2
    a[0] = 1'b1;
    step(4);
    en = 1'b0;
    for (int e = 5; e <= 14; e++) begin
      step(1);
      chk("frz_y0", y[0], 1'b1);
      chk("frz_fall0", fall[0], 1'b0);
    end
    en = 1'b1;
    step(1);
    chk("frz_y0_res1", y[0], 1'b1);
    step(1);
    chk("frz_y0_res2", y[0], 1'b0);
    chk("frz_fall0_res", fall[0], 1'b1);
    a[0] = 1'b0;
    step(8);
    chk("frz_y0_ret", y[0], 1'b1);

    // Reset mid-count
    a[0] = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    chk("rmc_y_rst", y, 6'b111111);
    chk("rmc_fall_rst", fall, 6'b0);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk("rmc_y0_hold", y[0], 1'b1);
      chk("rmc_rise_hold", rise, 6'b0);
    end
    step(1);
    chk("rmc_y", y, 6'b010100);
    chk("rmc_fall", fall, 6'b101011);

    // Mixed polarity on dut2
    chk("mix_y_rst", y2, 6'b111110);
    chk("mix_rise_rst", rise2, 6'b0);
    rst2 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk("mix_y_hold", y2, 6'b111110);
      chk("mix_rise_hold", rise2, 6'b0);
      chk("mix_fall_hold", fall2, 6'b0);
    end
    step(1);
    chk("mix_y", y2, 6'b111101);
    chk("mix_rise", rise2, 6'b000001);
    chk("mix_fall", fall2, 6'b000010);
    step(1);
    chk("mix_rise_clr", rise2, 6'b0);
    chk("mix_fall_clr", fall2, 6'b0);
    chk("mix_y_keep", y2, 6'b111101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
